// File: rtl/imm_gen_pipe.sv
// Elastic-pipelined RV32I/RV64I immediate generator: decodes and sign-extends the
// immediate of each accepted instruction into a 2-entry output FIFO, counting illegal opcodes.
module imm_gen_pipe #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       fmt,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_IMM_32   = 7'b0011011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;

    // One FIFO entry: {illegal, fmt, imm}
    localparam int E = XLEN + 4;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic            w_is_shift;
    logic [2:0]      w_fmt;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic            w_illegal;
    logic [E-1:0]    w_new_entry;

    logic [1:0]       r_cnt;
    logic [CNT_W-1:0] r_illegal_cnt;
    logic             w_push;
    logic             w_pop;

    logic [1:0]          w_load;
    logic [1:0][E-1:0]   w_data;
    logic [1:0][E-1:0]   w_slot_q;

    assign w_opcode   = instruction[6:0];
    assign w_funct3   = instruction[14:12];
    assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

    always_comb begin
        w_fmt = FMT_NONE;
        case (w_opcode)
            OP_LOAD, OP_JALR: w_fmt = FMT_I;
            OP_IMM:           w_fmt = w_is_shift ? FMT_SHAMT : FMT_I;
            OP_IMM_32: begin
                if (XLEN == 64) begin
                    w_fmt = w_is_shift ? FMT_SHAMT : FMT_I;
                end
            end
            OP_STORE:         w_fmt = FMT_S;
            OP_BRANCH:        w_fmt = FMT_B;
            OP_LUI, OP_AUIPC: w_fmt = FMT_U;
            OP_JAL:           w_fmt = FMT_J;
            default:          w_fmt = FMT_NONE;
        endcase
    end

    // Build a 32-bit immediate first; every format (incl. zero-extended shamt) then
    // widens to XLEN by plain sign extension since shamt keeps bit 31 clear.
    always_comb begin
        w_imm32 = 32'd0;
        case (w_fmt)
            FMT_I: w_imm32 = {{20{instruction[31]}}, instruction[31:20]};
            FMT_S: w_imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            FMT_B: w_imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                              instruction[30:25], instruction[11:8], 1'b0};
            FMT_U: w_imm32 = {instruction[31:12], 12'd0};
            FMT_J: w_imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                              instruction[20], instruction[30:21], 1'b0};
            FMT_SHAMT: begin
                if (XLEN == 64 && w_opcode == OP_IMM) begin
                    w_imm32 = {26'd0, instruction[25:20]};
                end else begin
                    w_imm32 = {27'd0, instruction[24:20]};
                end
            end
            default: w_imm32 = 32'd0;
        endcase
    end

    assign w_imm       = XLEN'($signed(w_imm32));
    assign w_illegal   = (w_fmt == FMT_NONE);
    assign w_new_entry = {w_illegal, w_fmt, w_imm};

    assign in_ready  = (r_cnt != 2'd2);
    assign out_valid = (r_cnt != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Slot 0 is always the head; slot 1 shifts down when the head leaves a full buffer.
    assign w_load[0] = (w_push && (r_cnt == 2'd0 || (r_cnt == 2'd1 && w_pop)))
                     || (w_pop && r_cnt == 2'd2);
    assign w_load[1] = w_push && (r_cnt == 2'd1) && !w_pop;
    assign w_data[0] = (r_cnt == 2'd2) ? w_slot_q[1] : w_new_entry;
    assign w_data[1] = w_new_entry;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            logic [E-1:0] r_slot;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_slot <= '0;
                end else if (w_load[gi]) begin
                    r_slot <= w_data[gi];
                end
            end
            assign w_slot_q[gi] = r_slot;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_illegal_cnt <= '0;
        end else if (w_push && w_illegal && (r_illegal_cnt != {CNT_W{1'b1}})) begin
            r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
        end
    end

    assign imm         = w_slot_q[0][XLEN-1:0];
    assign fmt         = w_slot_q[0][XLEN+2:XLEN];
    assign illegal     = w_slot_q[0][XLEN+3];
    assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: an XLEN=64/CNT_W=16 instance and an
// XLEN=32/CNT_W=2 instance, each with its own handshake signals and reset.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // XLEN=64 instance
    logic        rst_a, iv_a, ir_a, ov_a, or_a, ill_a;
    logic [31:0] ins_a;
    logic [63:0] imm_a;
    logic [2:0]  fmt_a;
    logic [15:0] cnt_a;

    // XLEN=32, CNT_W=2 instance
    logic        rst_b, iv_b, ir_b, ov_b, or_b, ill_b;
    logic [31:0] ins_b;
    logic [31:0] imm_b;
    logic [2:0]  fmt_b;
    logic [1:0]  cnt_b;

    imm_gen_pipe #(.XLEN(64), .CNT_W(16)) u_a (
        .clk(clk), .reset(rst_a), .in_valid(iv_a), .in_ready(ir_a), .instruction(ins_a),
        .out_valid(ov_a), .out_ready(or_a), .imm(imm_a), .fmt(fmt_a), .illegal(ill_a),
        .illegal_cnt(cnt_a)
    );

    imm_gen_pipe #(.XLEN(32), .CNT_W(2)) u_b (
        .clk(clk), .reset(rst_b), .in_valid(iv_b), .in_ready(ir_b), .instruction(ins_b),
        .out_valid(ov_b), .out_ready(or_b), .imm(imm_b), .fmt(fmt_b), .illegal(ill_b),
        .illegal_cnt(cnt_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One instruction through the 64-bit instance with out_ready=1.
    task automatic xfer_a(input string tag, input logic [31:0] ins,
                          input logic [63:0] e_imm, input logic [2:0] e_fmt, input logic e_ill);
        check({tag, ".in_ready"}, 64'(ir_a), 64'd1);
        iv_a  = 1'b1;
        ins_a = ins;
        tick();
        iv_a = 1'b0;
        check({tag, ".out_valid"}, 64'(ov_a), 64'd1);
        check({tag, ".imm"}, imm_a, e_imm);
        check({tag, ".fmt"}, 64'(fmt_a), 64'(e_fmt));
        check({tag, ".illegal"}, 64'(ill_a), 64'(e_ill));
        $display("xfer64 %s instr=%08h imm=%016h fmt=%0d illegal=%0b", tag, ins, imm_a, fmt_a, ill_a);
    endtask

    task automatic xfer_b(input string tag, input logic [31:0] ins,
                          input logic [31:0] e_imm, input logic [2:0] e_fmt, input logic e_ill,
                          input logic [1:0] e_cnt);
        iv_b  = 1'b1;
        ins_b = ins;
        tick();
        iv_b = 1'b0;
        check({tag, ".out_valid"}, 64'(ov_b), 64'd1);
        check({tag, ".imm"}, 64'(imm_b), 64'(e_imm));
        check({tag, ".fmt"}, 64'(fmt_b), 64'(e_fmt));
        check({tag, ".illegal"}, 64'(ill_b), 64'(e_ill));
        check({tag, ".cnt"}, 64'(cnt_b), 64'(e_cnt));
        $display("xfer32 %s instr=%08h imm=%08h fmt=%0d illegal=%0b cnt=%0d", tag, ins, imm_b, fmt_b, ill_b, cnt_b);
    endtask

    initial begin
        rst_a = 1'b1; iv_a = 1'b0; or_a = 1'b1; ins_a = 32'd0;
        rst_b = 1'b1; iv_b = 1'b0; or_b = 1'b1; ins_b = 32'd0;
        tick();
        tick();
        check("rst.out_valid", 64'(ov_a), 64'd0);
        check("rst.in_ready", 64'(ir_a), 64'd1);
        check("rst.imm", imm_a, 64'd0);
        check("rst.fmt", 64'(fmt_a), 64'd0);
        check("rst.illegal", 64'(ill_a), 64'd0);
        check("rst.cnt", 64'(cnt_a), 64'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Basic formats and sign extension, back-to-back with out_ready=1
        xfer_a("load",    32'h00202183, 64'd2, 3'd1, 1'b0);
        xfer_a("store",   32'h005605A3, 64'd11, 3'd2, 1'b0);
        xfer_a("beq",     32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0);
        xfer_a("lui",     32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
        xfer_a("jal",     32'h0010006F, 64'd2048, 3'd5, 1'b0);
        xfer_a("slli",    32'h03F09093, 64'd63, 3'd6, 1'b0);
        xfer_a("srai",    32'h43F0D093, 64'd63, 3'd6, 1'b0);
        xfer_a("addiw",   32'hFFF0009B, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
        xfer_a("slliw",   32'h03F0909B, 64'd31, 3'd6, 1'b0);
        check("pre_ill.cnt", 64'(cnt_a), 64'd0);
        xfer_a("illegal", 32'h0000007F, 64'd0, 3'd0, 1'b1);
        check("ill.cnt", 64'(cnt_a), 64'd1);
        tick();
        check("drain.out_valid", 64'(ov_a), 64'd0);

        // Backpressure: A, B fill the buffer, C is held by the source
        or_a = 1'b0;
        iv_a = 1'b1; ins_a = 32'h00202183;
        tick();
        check("bp.A.in_ready", 64'(ir_a), 64'd1);
        check("bp.A.imm", imm_a, 64'd2);
        ins_a = 32'h005605A3;
        tick();
        check("bp.B.in_ready", 64'(ir_a), 64'd0);
        check("bp.B.head", imm_a, 64'd2);
        ins_a = 32'hFE000EE3;
        tick();
        check("bp.C.in_ready", 64'(ir_a), 64'd0);
        check("bp.C.head_stable", imm_a, 64'd2);
        check("bp.C.out_valid", 64'(ov_a), 64'd1);
        $display("bp stall out_valid=%0b in_ready=%0b imm=%0h", ov_a, ir_a, imm_a);
        or_a = 1'b1;
        tick();
        check("bp.popA.head", imm_a, 64'd11);
        check("bp.popA.in_ready", 64'(ir_a), 64'd1);
        tick();
        iv_a = 1'b0;
        check("bp.popB.head", imm_a, 64'hFFFF_FFFF_FFFF_FFFC);
        check("bp.popB.fmt", 64'(fmt_a), 64'd3);
        check("bp.popB.out_valid", 64'(ov_a), 64'd1);
        tick();
        check("bp.popC.out_valid", 64'(ov_a), 64'd0);
        $display("bp drained out_valid=%0b in_ready=%0b", ov_a, ir_a);

        // Reset while the buffer is full
        or_a = 1'b0;
        iv_a = 1'b1; ins_a = 32'h0000007F;
        tick();
        ins_a = 32'h0010006F;
        tick();
        iv_a = 1'b0;
        check("mid.full.in_ready", 64'(ir_a), 64'd0);
        check("mid.full.cnt", 64'(cnt_a), 64'd2);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        check("mid.rst.out_valid", 64'(ov_a), 64'd0);
        check("mid.rst.in_ready", 64'(ir_a), 64'd1);
        check("mid.rst.cnt", 64'(cnt_a), 64'd0);
        check("mid.rst.imm", imm_a, 64'd0);
        or_a = 1'b1;
        xfer_a("post_rst", 32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
        tick();
        check("post_rst.no_stale", 64'(ov_a), 64'd0);

        // XLEN=32, CNT_W=2 instance
        xfer_b("b.slli",  32'h03F09093, 32'd31, 3'd6, 1'b0, 2'd0);
        xfer_b("b.opimm32", 32'h0000009B, 32'd0, 3'd0, 1'b1, 2'd1);
        xfer_b("b.lui",   32'h800000B7, 32'h8000_0000, 3'd4, 1'b0, 2'd1);
        xfer_b("b.ill2",  32'h0000007F, 32'd0, 3'd0, 1'b1, 2'd2);
        xfer_b("b.ill3",  32'h0000007F, 32'd0, 3'd0, 1'b1, 2'd3);
        xfer_b("b.ill4",  32'h0000007F, 32'd0, 3'd0, 1'b1, 2'd3);
        xfer_b("b.ill5",  32'h0000007F, 32'd0, 3'd0, 1'b1, 2'd3);
        tick();
        check("b.drain.out_valid", 64'(ov_b), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
